// File: rtl/hilo_muldiv_pkg.sv
// Shared op codes, MT/MF selectors and default latencies for the HI/LO
// multiply/divide unit and the instruction decoder that drives it.
package hilo_muldiv_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] MUL_MULTU = 4'b0000;
  localparam logic [3:0] MUL_MULT  = 4'b0001;
  localparam logic [3:0] MUL_DIVU  = 4'b0010;
  localparam logic [3:0] MUL_DIV   = 4'b0011;
  localparam logic [3:0] MUL_MADDU = 4'b0100;
  localparam logic [3:0] MUL_MADD  = 4'b0101;
  localparam logic [3:0] MUL_MSUBU = 4'b0110;
  localparam logic [3:0] MUL_MSUB  = 4'b0111;
  localparam logic [3:0] MUL_NONE  = 4'b1000;

  localparam logic [1:0] MT_LO   = 2'b00;
  localparam logic [1:0] MT_HI   = 2'b01;
  localparam logic [1:0] MT_NONE = 2'b10;

  localparam logic [1:0] MF_NONE = 2'b00;
  localparam logic [1:0] MF_LO   = 2'b01;
  localparam logic [1:0] MF_HI   = 2'b10;

  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_DIV_LAT = 10;

  // Bits [2:1] of a start op select the operation family; bit [0] is signedness.
  typedef enum logic [1:0] {
    KIND_MUL  = 2'b00,
    KIND_DIV  = 2'b01,
    KIND_MADD = 2'b10,
    KIND_MSUB = 2'b11
  } op_kind_e;

  function automatic logic is_start_op(input logic [3:0] op);
    return ~op[3];
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return op[3:1] == 3'b001;
  endfunction

endpackage

// File: rtl/hilo_muldiv_datapath.sv
// Combinational result generator: maps latched op, operands and accumulator
// to the 64-bit {HI,LO} value, including accumulate and divide-by-zero rules.
module muldiv_datapath
  import hilo_muldiv_pkg::*;
(
  input  logic [2:0]          op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [2*DATA_W-1:0] acc,
  output logic [2*DATA_W-1:0] result
);

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic              neg);
    return neg ? -v : v;
  endfunction

  logic                       is_signed;
  op_kind_e                   kind;
  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] b_ext;
  logic signed [2*DATA_W-1:0] product;
  logic                       neg_a;
  logic                       neg_b;
  logic                       div_zero;
  logic [DATA_W-1:0]          mag_a;
  logic [DATA_W-1:0]          mag_b;
  logic [DATA_W-1:0]          uq;
  logic [DATA_W-1:0]          ur;
  logic [DATA_W-1:0]          quot;
  logic [DATA_W-1:0]          rem;

  assign is_signed = op[0];
  assign kind      = op_kind_e'(op[2:1]);

  // Zero- or sign-extending to 64 bits lets one signed multiplier serve both
  // flavours; the low 64 bits of the product are exact in either case.
  assign a_ext   = is_signed ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
  assign b_ext   = is_signed ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
  assign product = a_ext * b_ext;

  // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000.
  assign neg_a    = is_signed & a[DATA_W-1];
  assign neg_b    = is_signed & b[DATA_W-1];
  assign div_zero = (b == '0);
  assign mag_a    = magnitude(a, neg_a);
  assign mag_b    = div_zero ? DATA_W'(1) : magnitude(b, neg_b);
  assign uq       = mag_a / mag_b;
  assign ur       = mag_a % mag_b;
  assign quot     = (neg_a ^ neg_b) ? -uq : uq;
  assign rem      = neg_a ? -ur : ur;

  always_comb begin
    result = '0;
    case (kind)
      KIND_MUL:  result = product;
      KIND_MADD: result = acc + product;
      KIND_MSUB: result = acc - product;
      KIND_DIV:  result = div_zero ? {a, {DATA_W{1'b1}}} : {rem, quot};
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/hilo_muldiv.sv
// EX-stage multiply/divide unit owning the architectural HI/LO registers,
// with a latency counter, operand latches, stall request and MFHI/MFLO read mux.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [3:0]        mul_op,
  input  logic [1:0]        mthilo,
  input  logic [1:0]        mfhilo,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              busy,
  output logic              stall_req,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

  logic [CNT_W-1:0]    cnt;
  logic [2:0]          op_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [2*DATA_W-1:0] acc_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic [2*DATA_W-1:0] result;
  logic [2*DATA_W-1:0] acc_next;
  logic                done;
  logic                start;
  logic                mt_wr;

  muldiv_datapath u_datapath (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .acc    (acc_q),
    .result (result)
  );

  assign busy = (cnt != '0);
  assign done = (cnt == CNT_W'(1));

  // The final busy cycle also accepts a start so ops chain back-to-back; the
  // new accumulator then bypasses the result being written this same edge.
  assign start    = valid & is_start_op(mul_op) & (~busy | done);
  assign mt_wr    = valid & ~mthilo[1] & ~busy & ~start;
  assign acc_next = done ? result : {hi_q, lo_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      if (done) begin
        {hi_q, lo_q} <= result;
      end else if (mt_wr) begin
        if (mthilo == MT_HI) hi_q <= rs_data;
        else                 lo_q <= rs_data;
      end

      if (start) begin
        op_q  <= mul_op[2:0];
        a_q   <= rs_data;
        b_q   <= rt_data;
        acc_q <= acc_next;
        cnt   <= is_div_op(mul_op) ? DIV_CNT : MUL_CNT;
      end else if (busy) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign stall_req = busy | (valid & is_start_op(mul_op))
                   | (busy & valid & ((mfhilo != MF_NONE) | ~mthilo[1]));

  always_comb begin
    rd_data = '0;
    case (mfhilo)
      MF_LO:   rd_data = lo_q;
      MF_HI:   rd_data = hi_q;
      default: rd_data = '0;
    endcase
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: expected {HI,LO} values are queued with
// their due cycle at issue time and compared by a monitor when they fall due.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  localparam int TB_MUL_LAT = 5;
  localparam int TB_DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [3:0]  mul_op;
  logic [1:0]  mthilo;
  logic [1:0]  mfhilo;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic        stall_req;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  hilo_muldiv #(.MUL_LAT(TB_MUL_LAT), .DIV_LAT(TB_DIV_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (valid),
    .mul_op    (mul_op),
    .mthilo    (mthilo),
    .mfhilo    (mfhilo),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .busy      (busy),
    .stall_req (stall_req),
    .rd_data   (rd_data),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          id;
    logic [63:0] res;
  } sb_t;

  sb_t         sb_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_ops = 0;
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] acc);
    longint      sa, sb, q, r;
    logic [63:0] prod;
    sa = $signed(a);
    sb = $signed(b);
    prod = op[0] ? 64'(sa * sb) : ({32'b0, a} * {32'b0, b});
    case (op[2:1])
      2'b00: return prod;
      2'b10: return acc + prod;
      2'b11: return acc - prod;
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (op[0]) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Monitor: compare {HI,LO} on the cycle each queued result falls due.
  always @(negedge clk) begin
    if (rst_n && sb_q.size() > 0 && cyc == sb_q[0].due) begin
      sb_t e;
      e = sb_q.pop_front();
      chk($sformatf("hilo_op%0d", e.id), {hi, lo}, e.res);
    end
  end

  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit fixed, input logic [63:0] fexp);
    sb_t ent;
    ent.res = fixed ? fexp : ref_model(op, a, b, {mdl_hi, mdl_lo});
    ent.due = cyc + 1 + ((op[3:1] == 3'b001) ? TB_DIV_LAT : TB_MUL_LAT);
    ent.id  = n_ops++;
    sb_q.push_back(ent);
    {mdl_hi, mdl_lo} = ent.res;
    valid   = 1'b1;
    mul_op  = op;
    rs_data = a;
    rt_data = b;
    #1 chk("stall_on_start", stall_req, 1);
    @(posedge clk);
    #1 valid = 1'b0;
    mul_op = MUL_NONE;
  endtask

  task automatic wait_done(output int n);
    int guard = 0;
    n = 0;
    do begin
      @(negedge clk);
      if (busy) n++;
      guard++;
    end while (busy && guard < 40);
    if (busy) chk("busy_timeout", guard, 0);
  endtask

  task automatic mt_op(input logic [1:0] sel, input logic [31:0] d);
    if (sel == MT_LO) mdl_lo = d;
    else if (sel == MT_HI) mdl_hi = d;
    valid   = 1'b1;
    mthilo  = sel;
    rs_data = d;
    @(posedge clk);
    #1 valid = 1'b0;
    mthilo = MT_NONE;
    @(negedge clk);
    chk("mt_write", {hi, lo}, {mdl_hi, mdl_lo});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: cycle %0d reached, bound exceeded", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    logic [3:0]  op;
    logic [31:0] a, b, old_lo;

    rst_n = 1'b0; valid = 1'b0; mul_op = MUL_NONE; mthilo = MT_NONE;
    mfhilo = MF_NONE; rs_data = '0; rt_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_hilo", {hi, lo}, 64'h0);
    chk("reset_busy", busy, 0);
    chk("reset_stall", stall_req, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // MULT and MULTU of 0xFFFFFFFF x 2
    start_op(MUL_MULT, 32'hFFFF_FFFF, 32'h2, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    wait_done(n);
    chk("mult_busy_cycles", n, TB_MUL_LAT);
    mfhilo = MF_HI; #1 chk("rd_hi", rd_data, 32'hFFFF_FFFF);
    mfhilo = MF_LO; #1 chk("rd_lo", rd_data, 32'hFFFF_FFFE);
    mfhilo = 2'b11; #1 chk("rd_none", rd_data, 32'h0);
    mfhilo = MF_NONE;
    start_op(MUL_MULTU, 32'hFFFF_FFFF, 32'h2, 1, 64'h0000_0001_FFFF_FFFE);
    wait_done(n);

    // Divides: signed truncation, divide by zero, overflow corner
    start_op(MUL_DIV, 32'hFFFF_FFF9, 32'h2, 1, 64'hFFFF_FFFF_FFFF_FFFD);
    wait_done(n);
    chk("div_busy_cycles", n, TB_DIV_LAT);
    start_op(MUL_DIVU, 32'h1234, 32'h0, 1, 64'h0000_1234_FFFF_FFFF);
    wait_done(n);
    start_op(MUL_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 64'h0000_0000_8000_0000);
    wait_done(n);
    start_op(MUL_DIV, 32'hFFFF_FFFB, 32'h0, 1, 64'hFFFF_FFFB_FFFF_FFFF);
    wait_done(n);

    // MT then accumulate
    mt_op(MT_LO, 32'h5);
    mt_op(MT_HI, 32'h0);
    start_op(MUL_MADD, 32'h3, 32'h4, 1, 64'h0000_0000_0000_0011);
    wait_done(n);
    start_op(MUL_MSUBU, 32'h11, 32'h1, 1, 64'h0);
    wait_done(n);

    // MT and MF while busy: MT dropped, stall held, stale read
    old_lo = lo;
    start_op(MUL_MULT, 32'h7, 32'hFFFF_FFFD, 0, '0);
    @(negedge clk);
    valid = 1'b1; mthilo = MT_LO; rs_data = 32'hAA; mfhilo = MF_LO;
    #1 chk("stall_busy_mt", stall_req, 1);
    chk("rd_stale", rd_data, old_lo);
    @(posedge clk);
    #1 valid = 1'b0; mthilo = MT_NONE; mfhilo = MF_NONE;
    wait_done(n);
    chk("mt_ignored_lo", lo, mdl_lo);

    // Back-to-back: second start in the last busy cycle accumulates fresh result
    start_op(MUL_MULTU, 32'h3, 32'h4, 0, '0);
    repeat (TB_MUL_LAT) @(negedge clk);
    start_op(MUL_MADDU, 32'h2, 32'h3, 1, 64'h0000_0000_0000_0012);
    wait_done(n);
    chk("b2b_busy_cycles", n, TB_MUL_LAT);

    // Randomised ops against the reference model
    for (int i = 0; i < 16; i++) begin
      op = 4'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      start_op(op, a, b, 0, '0);
      wait_done(n);
      chk($sformatf("rand%0d_busy", i), n, (op[2:1] == 2'b01) ? TB_DIV_LAT : TB_MUL_LAT);
    end

    // valid=0 and out-of-range op codes do nothing
    mt_op(MT_LO, 32'h55);
    valid = 1'b0; mul_op = MUL_MULT; mthilo = MT_LO; rs_data = 32'h77;
    #1 chk("novalid_stall", stall_req, 0);
    @(posedge clk);
    #1 chk("novalid_busy", busy, 0);
    chk("novalid_lo", lo, mdl_lo);
    mthilo = MT_NONE;
    valid = 1'b1; mul_op = 4'b1001;
    #1 chk("badop_stall", stall_req, 0);
    @(posedge clk);
    #1 chk("badop_busy", busy, 0);
    valid = 1'b0; mul_op = MUL_NONE;
    @(negedge clk);

    // Reset in the 4th busy cycle of a divide aborts at once
    start_op(MUL_DIV, 32'h100, 32'h3, 0, '0);
    repeat (4) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    sb_q.delete();
    #1 chk("abort_hilo", {hi, lo}, 64'h0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_hi = '0; mdl_lo = '0;
    repeat (12) @(negedge clk);
    chk("abort_no_write", {hi, lo}, 64'h0);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
